// File: rtl/systolic_ctrl_pkg.sv
// Shared types and helpers for the systolic tile sequencer.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int TILE_SIZE    = 8;
  localparam int FEED_BEATS   = 2*TILE_SIZE - 1;
  localparam int CLEAR_CYCLES = 2;

  typedef struct packed {
    logic valid;
    int   idx;
  } skew_t;

  // Diagonal wavefront: lane sees element (t - lane) when that falls inside the tile.
  function automatic skew_t skew_sel(input int t, input int lane, input int size);
    skew_t s;
    int    d;
    d       = t - lane;
    s.valid = (d >= 0) && (d < size);
    s.idx   = s.valid ? d : 0;
    return s;
  endfunction

endpackage

// File: rtl/systolic_skew_mux.sv
// Per-lane skewed element select from a buffered tile (row-major storage).
module systolic_skew_mux
  import systolic_ctrl_pkg::*;
#(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TW         = 4,
  parameter bit COL_MAJOR  = 1'b0
) (
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0] tile,
  input  logic [TW-1:0]                   t,
  output logic [SIZE*DATA_WIDTH-1:0]      vec
);

  // A lanes walk along their own row; B lanes walk down their own column.
  always_comb begin
    vec = '0;
    for (int lane = 0; lane < SIZE; lane++) begin
      skew_t sel;
      int    e;
      sel = skew_sel(int'(t), lane, SIZE);
      e   = COL_MAJOR ? (sel.idx*SIZE + lane) : (lane*SIZE + sel.idx);
      if (sel.valid) vec[lane*DATA_WIDTH +: DATA_WIDTH] = tile[e*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Load/clear/feed/drain/result sequencer for the 8x8 systolic array.
// Optional SYSTOLIC_ACCUM_EN adds acc_keep to skip CLEAR for K-tiling.
//
// state | meaning
// LOAD  | accept load beats into A/B buffers
// CLEAR | hold arr_rst_n low to clear accumulators
// FEED  | drive skewed A/B vectors, t = 0..2*SIZE-2
// DRAIN | zero operands while the array pipeline settles
// DONE  | present result; next tile may load meanwhile
module systolic_tile_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int SIZE         = TILE_SIZE,
  parameter int DATA_WIDTH   = 8,
  parameter int DRAIN_CYCLES = SIZE + 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SIZE*DATA_WIDTH-1:0]       in_a_row,
  input  logic [SIZE*DATA_WIDTH-1:0]       in_b_col,
`ifdef SYSTOLIC_ACCUM_EN
  input  logic                             acc_keep,
`endif
  output logic                             arr_rst_n,
  output logic [SIZE*DATA_WIDTH-1:0]       arr_a,
  output logic [SIZE*DATA_WIDTH-1:0]       arr_b,
  input  logic [SIZE*SIZE*2*DATA_WIDTH-1:0] arr_c,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [SIZE*SIZE*2*DATA_WIDTH-1:0] res_c,
  output logic                             busy
);

  localparam int VW  = SIZE*DATA_WIDTH;
  localparam int TW  = $clog2(2*SIZE - 1);
  localparam int CW  = $clog2(SIZE + 1);
  localparam int TMW = $clog2(((DRAIN_CYCLES > CLEAR_CYCLES) ? DRAIN_CYCLES : CLEAR_CYCLES) + 1);

  localparam logic [CW-1:0]  SIZE_C    = CW'(SIZE);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(SIZE - 1);
  localparam logic [TW-1:0]  FEED_LAST = TW'(2*SIZE - 2);
  localparam logic [TMW-1:0] CLEAR_TC  = TMW'(CLEAR_CYCLES - 1);
  localparam logic [TMW-1:0] DRAIN_TC  = TMW'(DRAIN_CYCLES);

  state_t                  state;
  logic [CW-1:0]           beat_cnt;
  logic [TW-1:0]           feed_t;
  logic [TMW-1:0]          timer;
  logic [SIZE*VW-1:0]      a_tile;
  logic [SIZE*VW-1:0]      b_tile;
  logic [VW-1:0]           mux_a;
  logic [VW-1:0]           mux_b;
  logic                    beat;
  logic                    full_next;
  logic                    launch;
  logic                    skip;

  assign in_ready  = (state == ST_LOAD) || ((state == ST_DONE) && (beat_cnt != SIZE_C));
  assign busy      = (state != ST_LOAD);
  assign beat      = in_valid && in_ready;
  assign full_next = (beat_cnt == SIZE_C) || (beat && (beat_cnt == LAST_BEAT));
  assign launch    = ((state == ST_LOAD) && beat && (beat_cnt == LAST_BEAT)) ||
                     ((state == ST_DONE) && res_ready && full_next);

`ifdef SYSTOLIC_ACCUM_EN
  logic keep_q;
  assign skip = (beat && (beat_cnt == '0)) ? acc_keep : keep_q;
  always_ff @(posedge clk) begin
    if (rst)                           keep_q <= 1'b0;
    else if (beat && (beat_cnt == '0)) keep_q <= acc_keep;
  end
`else
  assign skip = 1'b0;
`endif

  // Both tiles stored row-major; beat k fills A row k and B column k.
  always_ff @(posedge clk) begin
    if (beat) begin
      a_tile[int'(beat_cnt)*VW +: VW] <= in_a_row;
      for (int r = 0; r < SIZE; r++)
        b_tile[(r*SIZE + int'(beat_cnt))*DATA_WIDTH +: DATA_WIDTH] <= in_b_col[r*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  systolic_skew_mux #(
    .SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .TW(TW), .COL_MAJOR(1'b0)
  ) u_skew_a (
    .tile(a_tile), .t(feed_t), .vec(mux_a)
  );

  systolic_skew_mux #(
    .SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .TW(TW), .COL_MAJOR(1'b1)
  ) u_skew_b (
    .tile(b_tile), .t(feed_t), .vec(mux_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      beat_cnt  <= '0;
      feed_t    <= '0;
      timer     <= '0;
      arr_rst_n <= 1'b1;
      arr_a     <= '0;
      arr_b     <= '0;
      res_valid <= 1'b0;
      res_c     <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (beat) beat_cnt <= beat_cnt + 1'b1;
        end
        ST_CLEAR: begin
          if (timer == '0) begin
            state     <= ST_FEED;
            feed_t    <= '0;
            arr_rst_n <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_FEED: begin
          arr_a <= mux_a;
          arr_b <= mux_b;
          if (feed_t == FEED_LAST) begin
            state <= ST_DRAIN;
            timer <= DRAIN_TC;
          end else begin
            feed_t <= feed_t + 1'b1;
          end
        end
        ST_DRAIN: begin
          arr_a <= '0;
          arr_b <= '0;
          if (timer == '0) begin
            res_c     <= arr_c;
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_DONE: begin
          if (beat) beat_cnt <= beat_cnt + 1'b1;
          if (res_ready) begin
            res_valid <= 1'b0;
            if (!full_next) state <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase

      // Tile start overrides the per-state updates above.
      if (launch) begin
        beat_cnt <= '0;
        if (skip) begin
          state  <= ST_FEED;
          feed_t <= '0;
        end else begin
          state     <= ST_CLEAR;
          timer     <= CLEAR_TC;
          arr_rst_n <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/systolic_tile_ctrl.md
Name: systolic_tile_ctrl

Overview:
Sequencer for the 8x8 Booth radix-8 systolic matrix array. It buffers one A tile (row by row) and one B tile (column by column) through a valid/ready load port, then clears the array accumulators. It next drives the skewed per-lane A/B vectors for 2*SIZE-1 cycles, waits out the array pipeline, and captures the product tile. The result is presented on a valid/ready result port.

Parameters:
SIZE, 8, matrix dimension / array lanes
DATA_WIDTH, 8, signed operand width; results are 2*DATA_WIDTH
DRAIN_CYCLES, SIZE+3, cycles after last feed beat until array C output is final (input reg + booth reg + PE chain)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  load beat valid
in_ready  out  1  controller accepts load beat
in_a_row  in  SIZE*DATA_WIDTH  row k of A; element c at bits [c*DATA_WIDTH +: DATA_WIDTH]
in_b_col  in  SIZE*DATA_WIDTH  column k of B; element r at bits [r*DATA_WIDTH +: DATA_WIDTH]
arr_rst_n  out  1  array reset (active-low), pulsed to clear accumulators
arr_a  out  SIZE*DATA_WIDTH  skewed A vector to array input A
arr_b  out  SIZE*DATA_WIDTH  skewed B vector to array input B
arr_c  in  SIZE*SIZE*2*DATA_WIDTH  array product output
res_valid  out  1  result tile valid
res_ready  in  1  consumer accepts result
res_c  out  SIZE*SIZE*2*DATA_WIDTH  captured tile; C[i][j] at [(i*SIZE+j)*2*DATA_WIDTH +: 2*DATA_WIDTH]
busy  out  1  high in every state except IDLE/LOAD

Behaviour:
- Reset outputs: in_ready=1, arr_rst_n=1, arr_a=0, arr_b=0, res_valid=0, res_c=0, busy=0. State=LOAD, beat counter=0. Buffers need no reset.
- States: LOAD -> CLEAR -> FEED -> DRAIN -> DONE -> LOAD.
- LOAD: in_ready=1. A beat transfers on in_valid&in_ready. Beat k writes A_buf row k and B_buf column k. Counter k increments per beat. When beat SIZE-1 transfers, go to CLEAR. in_valid low holds the state indefinitely.
- CLEAR: in_ready=0, arr_rst_n=0 for exactly 2 cycles, then FEED with t=0. arr_a/arr_b=0.
- FEED: t runs 0..2*SIZE-2, one cycle each.
  - arr_a lane i = A_buf[i][t-i] if 0<=t-i<SIZE, else 0.
  - arr_b lane j = B_buf[t-j][j] under the same rule.
  - Outputs are registered, so the array sees beat t one cycle after t is computed. The feed counter accounts for this.
  - After t=2*SIZE-2, go to DRAIN.
- DRAIN: arr_a=arr_b=0 (zero operands add nothing). Count DRAIN_CYCLES, then capture res_c<=arr_c and go to DONE.
- DONE: res_valid=1 and res_c held stable until res_valid&res_ready. On that cycle, res_valid<=0 and state returns to LOAD.
- Overlap: LOAD of the next tile is permitted while in DONE. in_ready=1 in DONE when the beat counter is <SIZE, so the buffers are free.
  - If all SIZE beats are loaded before the result is accepted, in_ready=0 until the handshake.
  - The handshake then goes directly to CLEAR.
- No new tile starts while res_valid=1 is unaccepted.
- rst mid-operation (any state): immediate return to reset values. A partial load is discarded and arr_rst_n is not asserted. The array is cleared by the next CLEAR.
- Width rule: res_c is taken verbatim from arr_c. No truncation or sign handling is done in the controller.
- Total latency from last load beat to res_valid: 2 + (2*SIZE-1) + DRAIN_CYCLES + 1 cycles. With defaults this is 29.

Optional Feature:
SYSTOLIC_ACCUM_EN
- Defined: adds input port acc_keep (1 bit), sampled on load beat 0. If acc_keep=1, CLEAR is skipped (LOAD -> FEED directly, arr_rst_n stays 1). The array accumulates onto the previous tile, giving C += A*B for K-tiling. Latency is reduced by 2.
- Undefined: no port; CLEAR is always executed.

Decomposition:
- Package systolic_ctrl_pkg holds:
  - the state enum (LOAD, CLEAR, FEED, DRAIN, DONE);
  - localparams FEED_BEATS=2*SIZE-1 and CLEAR_CYCLES=2;
  - a function computing the skew index valid/element select.
- One sub-module, systolic_skew_mux: combinational per-lane select of A_buf/B_buf element from t, instanced once for A and once for B. The controller FSM, counters and result register stay in the top.

Test Plan:
- A=identity, B[r][c]=r*8+c -> res_c equals B, sign-extended to 16 bits; res_valid rises 29 cycles after the last load beat.
- All A=-128, all B=-128 -> every C[i][j]=8*16384=131072 wrapped to 16 bits (0x0000), checked against a reference model with the same wrap.
- Random signed 8-bit tiles, res_ready held low 20 cycles -> res_c stable and res_valid held. Next tile loads during the stall, in_ready drops after 8 beats, and CLEAR starts the cycle after the handshake.
- in_valid toggled every other cycle during load -> exactly 8 transfers recorded, product correct.
- rst asserted at FEED t=5, then a fresh tile -> outputs return to reset values the next cycle; second result matches golden with no contamination from the aborted tile.
- With SYSTOLIC_ACCUM_EN, two tiles where the second has acc_keep=1 -> result = A1*B1 + A2*B2, with no arr_rst_n pulse before the second feed.
